// File: rtl/act_pkg.sv
// Shared definitions for the act_stream activation unit: mode encodings,
// float32 field positions and the default clamp ceiling.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CAP    = 2'd3
  } act_mode_e;

  localparam int FP_WIDTH = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MAN_HI   = 22;

  localparam logic [7:0]  EXP_MAX     = 8'd255;
  localparam logic [31:0] CAP_DEFAULT = 32'h40C0_0000;
  localparam logic [31:0] NEG_ZERO    = 32'h8000_0000;

  // Negative means sign set and not a signed zero.
  function automatic logic fp_is_neg(input logic [FP_WIDTH-1:0] x);
    return x[SIGN_BIT] && (x[EXP_HI:0] != '0);
  endfunction

endpackage

// File: rtl/act_lane.sv
// Combinational single-element float32 activation.
// Optional macro RELU_CAP_EN turns mode 3 into a ReLU clamped at CAP_VALUE.
module act_lane
  import act_pkg::*;
#(
  parameter int          LEAK_SHIFT = 3,
  parameter logic [31:0] CAP_VALUE  = CAP_DEFAULT
) (
  input  logic [FP_WIDTH-1:0] i_data,
  input  logic [1:0]          i_mode,
  output logic [FP_WIDTH-1:0] o_data,
  output logic                o_neg
);

  localparam logic [7:0] LS = 8'(LEAK_SHIFT);

  logic       w_s;
  logic [7:0] w_e;

  assign w_s   = i_data[SIGN_BIT];
  assign w_e   = i_data[EXP_HI:EXP_LO];
  assign o_neg = fp_is_neg(i_data);

  always_comb begin
    o_data = i_data;
    case (act_mode_e'(i_mode))
      ACT_BYPASS: o_data = i_data;
      ACT_RELU:   o_data = w_s ? '0 : i_data;
      ACT_LEAKY: begin
        // Inf/NaN pass through; results that would go denormal flush to -0.0.
        if (!w_s || w_e == EXP_MAX) o_data = i_data;
        else if (w_e <= LS)         o_data = NEG_ZERO;
        else                        o_data = {w_s, w_e - LS, i_data[MAN_HI:0]};
      end
`ifdef RELU_CAP_EN
      ACT_CAP: begin
        if (w_s)                                  o_data = '0;
        else if (i_data[EXP_HI:0] > CAP_VALUE[EXP_HI:0]) o_data = CAP_VALUE;
        else                                      o_data = i_data;
      end
`else
      ACT_CAP:    o_data = w_s ? '0 : i_data;
`endif
      default:    o_data = i_data;
    endcase
  end

endmodule

// File: rtl/act_stream.sv
// Two-stage valid/ready activation pipeline with a saturating negative counter.
// Optional macro RELU_CAP_EN enables the capped-ReLU mode in each lane.
module act_stream
  import act_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          LANES      = 4,
  parameter int          LEAK_SHIFT = 3,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] CAP_VALUE  = CAP_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  input  logic                        clear_count,
  output logic [CNT_WIDTH-1:0]        neg_count
);

  localparam int NW = $clog2(LANES + 1);
  localparam int SW = CNT_WIDTH + NW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (DATA_WIDTH != FP_WIDTH) begin : g_bad_width
    $error("act_stream: DATA_WIDTH must be 32 (float32)");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT > 30) begin : g_bad_shift
    $error("act_stream: LEAK_SHIFT must be in 1..30");
  end

  logic                                r_s1_valid;
  logic [LANES-1:0][DATA_WIDTH-1:0]    r_s1_data;
  logic [1:0]                          r_s1_mode;
  logic                                r_s2_valid;
  logic [LANES-1:0][DATA_WIDTH-1:0]    r_s2_data;
  logic [NW-1:0]                       r_s2_ncnt;
  logic [CNT_WIDTH-1:0]                r_cnt;

  logic [LANES-1:0][DATA_WIDTH-1:0]    w_act;
  logic [LANES-1:0]                    w_lane_neg;
  logic [NW-1:0]                       w_ncnt;
  logic                                w_s1_adv;
  logic                                w_in_hs;
  logic                                w_out_hs;
  logic [SW-1:0]                       w_sum;

  assign w_s1_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !rst && (!r_s1_valid || w_s1_adv);
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = r_s2_valid && out_ready;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign neg_count = r_cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .LEAK_SHIFT(LEAK_SHIFT),
      .CAP_VALUE (CAP_VALUE)
    ) u_lane (
      .i_data(r_s1_data[i]),
      .i_mode(r_s1_mode),
      .o_data(w_act[i]),
      .o_neg (w_lane_neg[i])
    );
  end

  always_comb begin
    w_ncnt = '0;
    for (int i = 0; i < LANES; i++) w_ncnt = w_ncnt + NW'(w_lane_neg[i]);
  end

  // Clear takes effect before the current beat's increment is added.
  assign w_sum = (clear_count ? '0 : SW'(r_cnt)) + SW'(r_s2_ncnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= '0;
    end else if (w_in_hs) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= in_data;
      r_s1_mode  <= mode;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_ncnt  <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_act;
        r_s2_ncnt <= w_ncnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              r_cnt <= '0;
    else if (w_out_hs)    r_cnt <= (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_WIDTH-1:0];
    else if (clear_count) r_cnt <= '0;
  end

endmodule

// File: tb/tb_act_stream.sv
// Self-checking bench for act_stream: directed vectors plus randomized streams
// against a spec-level reference model and scoreboard queue.
module tb_act_stream;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int W     = LANES * DW;
  localparam int CNTW  = 4;
  localparam int LS    = 3;
  localparam logic [31:0] CAP = 32'h40C0_0000;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 0;
  logic            rst = 1;
  logic [1:0]      mode = 0;
  logic            in_valid = 0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic            out_valid;
  logic            out_ready = 0;
  logic [W-1:0]    out_data;
  logic            clear_count = 0;
  logic [CNTW-1:0] neg_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           expn_q[$];
  int           model_cnt = 0;

  always #5 clk = ~clk;

  act_stream #(
    .DATA_WIDTH(DW), .LANES(LANES), .LEAK_SHIFT(LS), .CNT_WIDTH(CNTW), .CAP_VALUE(CAP)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clear_count(clear_count), .neg_count(neg_count)
  );

  // Reference activation straight from the per-element rules.
  function automatic logic [31:0] ref_elem(input logic [31:0] x, input logic [1:0] m);
    bit sgn = x[31];
    int e   = int'(x[30:23]);
    logic [31:0] r;
    r = x;
    if (m == 2'd1) r = sgn ? 32'h0 : x;
    else if (m == 2'd2) begin
      if (sgn && e != 255) begin
        if (e <= LS) r = 32'h8000_0000;
        else begin
          r = x;
          r[30:23] = 8'(e - LS);
        end
      end
    end else if (m == 2'd3) begin
`ifdef RELU_CAP_EN
      if (sgn) r = 32'h0;
      else if (x[30:0] > CAP[30:0]) r = CAP;
`else
      r = sgn ? 32'h0 : x;
`endif
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = ref_elem(d[i*DW +: DW], m);
    return r;
  endfunction

  function automatic int ref_negs(input logic [W-1:0] d);
    int n = 0;
    for (int i = 0; i < LANES; i++) begin
      logic [31:0] x = d[i*DW +: DW];
      if (x[31] && x[30:0] != 0) n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] rnd_elem();
    logic [31:0] x = $urandom;
    case ($urandom_range(0, 5))
      0: x[30:23] = 8'($urandom_range(0, 4));
      1: x[30:23] = 8'd255;
      2: x[30:0]  = '0;
      3: x[30:23] = 8'($urandom_range(125, 135));
      default: ;
    endcase
    return x;
  endfunction

  function automatic logic [W-1:0] rnd_beat();
    logic [W-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = rnd_elem();
    return d;
  endfunction

  // One cycle: drive inputs at negedge, report what handshakes at the next posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] m,
                      input logic ordy, input logic clr,
                      output logic ihs, output logic ohs, output logic ov,
                      output logic irdy, output logic [W-1:0] od);
    @(negedge clk);
    in_valid = v; in_data = d; mode = m; out_ready = ordy; clear_count = clr;
    #1;
    ihs = in_valid && in_ready;
    ohs = out_valid && out_ready;
    ov = out_valid; irdy = in_ready; od = out_data;
  endtask

  // Scoreboard bookkeeping only; callers do the comparing.
  task automatic track(input logic ihs, input logic ohs, input logic clr,
                       input logic [W-1:0] d, input logic [1:0] m,
                       output bit got, output bit spur, output logic [W-1:0] exp_o);
    got = 0; spur = 0; exp_o = '0;
    if (ohs) begin
      if (exp_q.size() == 0) spur = 1;
      else begin
        int n;
        got = 1;
        exp_o = exp_q.pop_front();
        n = expn_q.pop_front();
        model_cnt = (clr ? 0 : model_cnt) + n;
        if (model_cnt > CMAX) model_cnt = CMAX;
      end
    end else if (clr) model_cnt = 0;
    if (ihs) begin
      exp_q.push_back(ref_beat(d, m));
      expn_q.push_back(ref_negs(d));
    end
  endtask

  task automatic idle_clear();
    logic ihs, ohs, ov, irdy; logic [W-1:0] od; bit got, spur; logic [W-1:0] e;
    step(0, '0, 0, 0, 1, ihs, ohs, ov, irdy, od);
    track(ihs, ohs, 1, '0, 0, got, spur, e);
  endtask

  task automatic test_reset();
    logic ihs, ohs, ov, irdy; logic [W-1:0] od;
    rst = 1;
    repeat (2) step(0, '0, 0, 1, 0, ihs, ohs, ov, irdy, od);
    checks++; if (irdy !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", irdy); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", ov); end
    checks++; if (od !== '0) begin errors++; $display("FAIL reset_out_data got=%h want=0", od); end
    checks++; if (neg_count !== '0) begin errors++; $display("FAIL reset_neg_count got=%0d want=0", neg_count); end
    rst = 0;
    step(0, '0, 0, 1, 0, ihs, ohs, ov, irdy, od);
    checks++; if (irdy !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b want=1", irdy); end
  endtask

  // Single beat, out_ready high: verify 2-cycle latency and the vector itself.
  task automatic test_one_beat(input string name, input logic [W-1:0] d, input logic [1:0] m,
                               input logic [W-1:0] want, input int want_neg);
    logic ihs, ohs, ov, irdy; logic [W-1:0] od; bit got, spur; logic [W-1:0] e;
    idle_clear();
    step(1, d, m, 1, 0, ihs, ohs, ov, irdy, od);
    track(ihs, ohs, 0, d, m, got, spur, e);
    checks++; if (ihs !== 1'b1) begin errors++; $display("FAIL %s_accept got=%b want=1", name, ihs); end
    step(0, '0, 0, 1, 0, ihs, ohs, ov, irdy, od);
    track(ihs, ohs, 0, '0, 0, got, spur, e);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL %s_early got=%b want=0", name, ov); end
    step(0, '0, 0, 1, 0, ihs, ohs, ov, irdy, od);
    track(ihs, ohs, 0, '0, 0, got, spur, e);
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL %s_latency got=%b want=1", name, ov); end
    checks++; if (od !== want) begin errors++; $display("FAIL %s_data got=%h want=%h", name, od, want); end
    checks++; if (got && od !== e) begin errors++; $display("FAIL %s_model got=%h want=%h", name, od, e); end
    step(0, '0, 0, 0, 0, ihs, ohs, ov, irdy, od);
    checks++; if (neg_count !== CNTW'(want_neg)) begin errors++; $display("FAIL %s_neg got=%0d want=%0d", name, neg_count, want_neg); end
  endtask

  task automatic test_backpressure();
    logic ihs, ohs, ov, irdy; logic [W-1:0] od; bit got, spur; logic [W-1:0] e;
    logic [W-1:0] d, prev_od; logic [1:0] m; logic ordy;
    int sent = 0, recv = 0, cyc = 0; bit stalled = 0, order_ok = 1;
    idle_clear();
    d = rnd_beat(); m = 2'($urandom);
    while (recv < 8 && cyc < 200) begin
      ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
      step(sent < 8, d, m, ordy, 0, ihs, ohs, ov, irdy, od);
      if (stalled) begin
        checks++;
        if (ov !== 1'b1 || od !== prev_od) begin
          errors++; $display("FAIL bp_stable got=%b/%h want=1/%h", ov, od, prev_od);
        end
      end
      if (exp_q.size() == 2 && !ordy) begin
        checks++; if (irdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%b want=0", irdy); end
      end
      stalled = ov && !ordy; prev_od = od;
      track(ihs, ohs, 0, d, m, got, spur, e);
      if (spur) begin errors++; checks++; $display("FAIL bp_spurious got=%h want=none", od); end
      if (got) begin
        recv++;
        if (od !== e) begin order_ok = 0; $display("FAIL bp_data got=%h want=%h", od, e); end
      end
      if (ihs) begin sent++; d = rnd_beat(); m = 2'($urandom); end
      cyc++;
    end
    checks++; if (!order_ok) errors++;
    checks++; if (recv != 8) begin errors++; $display("FAIL bp_count got=%0d want=8", recv); end
    step(0, '0, 0, 0, 0, ihs, ohs, ov, irdy, od);
    checks++; if (neg_count !== CNTW'(model_cnt)) begin errors++; $display("FAIL bp_neg got=%0d want=%0d", neg_count, model_cnt); end
  endtask

  task automatic test_back_to_back();
    logic ihs, ohs, ov, irdy; logic [W-1:0] od; bit got, spur; logic [W-1:0] e;
    logic [W-1:0] d; logic [1:0] m;
    int recv = 0, bad = 0, stalls = 0;
    idle_clear();
    for (int c = 0; c < 24; c++) begin
      d = rnd_beat(); m = 2'($urandom);
      step(c < 20, d, m, 1, 0, ihs, ohs, ov, irdy, od);
      if (c < 20 && !ihs) stalls++;
      if (c >= 2 && c < 22 && !ohs) stalls++;
      track(ihs, ohs, 0, d, m, got, spur, e);
      if (spur) bad++;
      if (got) begin recv++; if (od !== e) begin bad++; $display("FAIL b2b_data got=%h want=%h", od, e); end end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_errors got=%0d want=0", bad); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_throughput got=%0d want=0", stalls); end
    checks++; if (recv != 20) begin errors++; $display("FAIL b2b_count got=%0d want=20", recv); end
    step(0, '0, 0, 0, 0, ihs, ohs, ov, irdy, od);
    checks++; if (neg_count !== CNTW'(model_cnt)) begin errors++; $display("FAIL b2b_neg got=%0d want=%0d", neg_count, model_cnt); end
  endtask

  task automatic test_saturation();
    logic ihs, ohs, ov, irdy; logic [W-1:0] od; bit got, spur; logic [W-1:0] e;
    logic [W-1:0] dneg, dtwo;
    int waited = 0;
    dneg = {32'hC000_0000, 32'hBF80_0000, 32'h8000_0001, 32'hFF80_0000};
    dtwo = {32'h4000_0000, 32'hC100_0000, 32'h8000_0000, 32'hBF80_0000};
    idle_clear();
    for (int i = 0; i < 5; i++) begin
      step(1, dneg, 0, 1, 0, ihs, ohs, ov, irdy, od);
      track(ihs, ohs, 0, dneg, 0, got, spur, e);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 0, 1, 0, ihs, ohs, ov, irdy, od);
      track(ihs, ohs, 0, '0, 0, got, spur, e);
    end
    checks++; if (neg_count !== 4'd15) begin errors++; $display("FAIL sat_value got=%0d want=15", neg_count); end
    step(1, dneg, 0, 1, 0, ihs, ohs, ov, irdy, od);
    track(ihs, ohs, 0, dneg, 0, got, spur, e);
    repeat (3) begin
      step(0, '0, 0, 1, 0, ihs, ohs, ov, irdy, od);
      track(ihs, ohs, 0, '0, 0, got, spur, e);
    end
    checks++; if (neg_count !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d want=15", neg_count); end
    step(1, dtwo, 0, 0, 0, ihs, ohs, ov, irdy, od);
    track(ihs, ohs, 0, dtwo, 0, got, spur, e);
    do begin
      step(0, '0, 0, 0, 0, ihs, ohs, ov, irdy, od);
      waited++;
    end while (!ov && waited < 10);
    step(0, '0, 0, 1, 1, ihs, ohs, ov, irdy, od);
    track(ihs, ohs, 1, '0, 0, got, spur, e);
    checks++; if (!ohs) begin errors++; $display("FAIL sat_clear_hs got=%b want=1", ohs); end
    step(0, '0, 0, 0, 0, ihs, ohs, ov, irdy, od);
    checks++; if (neg_count !== 4'd2) begin errors++; $display("FAIL sat_clear_add got=%0d want=2", neg_count); end
    checks++; if (neg_count !== CNTW'(model_cnt)) begin errors++; $display("FAIL sat_model got=%0d want=%0d", neg_count, model_cnt); end
  endtask

  task automatic test_cap();
    logic [W-1:0] d, want;
    d = {32'hC000_0000, 32'h7F80_0000, 32'h40B3_3333, 32'h40E0_0000};
`ifdef RELU_CAP_EN
    want = {32'h0000_0000, 32'h40C0_0000, 32'h40B3_3333, 32'h40C0_0000};
`else
    want = {32'h0000_0000, 32'h7F80_0000, 32'h40B3_3333, 32'h40E0_0000};
`endif
    test_one_beat("cap", d, 2'd3, want, 1);
  endtask

  task automatic test_reset_midstream();
    logic ihs, ohs, ov, irdy; logic [W-1:0] od; bit got, spur; logic [W-1:0] e;
    logic [W-1:0] d; int n = 0, late = 0;
    idle_clear();
    do begin
      d = rnd_beat();
      d[31:0] = 32'hC000_0000;
      step(1, d, 1, 0, 0, ihs, ohs, ov, irdy, od);
      track(ihs, ohs, 0, d, 1, got, spur, e);
      n++;
    end while (ihs && n < 10);
    checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL mid_fill got=%0d want=2", exp_q.size()); end
    rst = 1;
    step(0, '0, 0, 0, 0, ihs, ohs, ov, irdy, od);
    checks++; if (irdy !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got=%b want=0", irdy); end
    step(0, '0, 0, 0, 0, ihs, ohs, ov, irdy, od);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b want=0", ov); end
    checks++; if (neg_count !== '0) begin errors++; $display("FAIL mid_rst_neg got=%0d want=0", neg_count); end
    rst = 0;
    exp_q.delete(); expn_q.delete(); model_cnt = 0;
    step(0, '0, 0, 1, 0, ihs, ohs, ov, irdy, od);
    checks++; if (irdy !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got=%b want=1", irdy); end
    repeat (5) begin
      step(0, '0, 0, 1, 0, ihs, ohs, ov, irdy, od);
      if (ov) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL mid_stale got=%0d want=0", late); end
    checks++; if (neg_count !== '0) begin errors++; $display("FAIL mid_neg_after got=%0d want=0", neg_count); end
  endtask

  initial begin
    test_reset();
    test_one_beat("relu", {32'h8000_0000, 32'h0000_0002, 32'h40B3_3333, 32'hC126_6666}, 2'd1,
                  {32'h0000_0000, 32'h0000_0002, 32'h40B3_3333, 32'h0000_0000}, 1);
    test_one_beat("leaky", {32'h40B3_3333, 32'hFFC0_0000, 32'h8100_0000, 32'hC126_6666}, 2'd2,
                  {32'h40B3_3333, 32'hFFC0_0000, 32'h8000_0000, 32'hBFA6_6666}, 3);
    test_one_beat("bypass", {32'h8000_0000, 32'hFFC0_0000, 32'h8100_0000, 32'hC126_6666}, 2'd0,
                  {32'h8000_0000, 32'hFFC0_0000, 32'h8100_0000, 32'hC126_6666}, 3);
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_cap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
